// File: rtl/elev_pkg.sv
// Shared types for the elevator floor scheduler: FSM states, direction codes, floor numbers.
package elev_pkg;

    typedef logic [3:0] floor_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR
    } state_t;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_IDLE = 2'b00;
    localparam dir_t DIR_UP   = 2'b01;
    localparam dir_t DIR_DOWN = 2'b10;

endpackage

// File: rtl/floor_sched_pick.sv
// floor_pick: nearest pending floor above/below the car and the preferred travel direction.
module floor_pick
    import elev_pkg::*;
#(
    parameter int N_FLOORS = 8
) (
    input  logic [N_FLOORS-1:0] pending,
    input  floor_t              now_floor,
    input  dir_t                dir,
    output floor_t              above,
    output floor_t              below,
    output logic                has_above,
    output logic                has_below,
    output logic                go_up,
    output logic                go_any
);

    floor_t up_dist;
    floor_t dn_dist;

    always_comb begin
        above     = '0;
        has_above = 1'b0;
        // Descending scan: the last hit is the lowest floor above the car.
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (floor_t'(i + 1) > now_floor)) begin
                above     = floor_t'(i + 1);
                has_above = 1'b1;
            end
        end
        below     = '0;
        has_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (floor_t'(i + 1) < now_floor)) begin
                below     = floor_t'(i + 1);
                has_below = 1'b1;
            end
        end
    end

    assign up_dist = above - now_floor;
    assign dn_dist = now_floor - below;
    assign go_any  = has_above | has_below;

    // Keep the travel direction while work remains that way; from idle pick the nearest, ties go up.
    always_comb begin
        case (dir)
            DIR_UP:   go_up = has_above;
            DIR_DOWN: go_up = has_above && !has_below;
            default:  go_up = has_above && (!has_below || (up_dist <= dn_dist));
        endcase
    end

endmodule

// File: rtl/floor_sched.sv
// Elevator floor scheduler: latches calls, drives target floor, direction and door timing.
// Optional FLOOR_SCHED_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
module floor_sched
    import elev_pkg::*;
#(
    parameter int N_FLOORS  = 8,
    parameter int DOOR_TIME = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] call_req,
    input  floor_t              now_floor,
    input  logic                arr,
`ifdef FLOOR_SCHED_DOOR_HOLD_EN
    input  logic                door_hold,
`endif
    output floor_t              des_floor,
    output logic                door_open,
    output dir_t                dir,
    output logic [N_FLOORS-1:0] pending
);

    localparam int             CW       = $clog2(DOOR_TIME);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(DOOR_TIME - 1);

    state_t              state, state_n;
    floor_t              des_n;
    logic                door_n;
    dir_t                dir_n;
    logic [N_FLOORS-1:0] pend_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                armed;

    logic [N_FLOORS-1:0] here_mask;
    logic                floor_ok, at_here, call_here, reload;
    logic                enter_door, pick_new, clr;

    floor_t above, below;
    logic   has_above, has_below, go_up, go_any;

    floor_pick #(.N_FLOORS(N_FLOORS)) u_pick (
        .pending   (pending),
        .now_floor (now_floor),
        .dir       (dir),
        .above     (above),
        .below     (below),
        .has_above (has_above),
        .has_below (has_below),
        .go_up     (go_up),
        .go_any    (go_any)
    );

    always_comb begin
        for (int i = 0; i < N_FLOORS; i++) here_mask[i] = (now_floor == floor_t'(i + 1));
    end

    assign floor_ok  = (now_floor != '0) && (now_floor <= floor_t'(N_FLOORS));
    assign at_here   = |(pending & here_mask);
    assign call_here = |(call_req & here_mask);
`ifdef FLOOR_SCHED_DOOR_HOLD_EN
    assign reload    = call_here | door_hold;
`else
    assign reload    = call_here;
`endif

    always_comb begin
        state_n    = state;
        des_n      = des_floor;
        door_n     = door_open;
        dir_n      = dir;
        cnt_n      = cnt;
        enter_door = 1'b0;
        pick_new   = 1'b0;
        clr        = 1'b0;
        case (state)
            S_IDLE: begin
                des_n = now_floor;
                if (at_here) enter_door = 1'b1;
                else         pick_new   = 1'b1;
            end
            S_UP: begin
                // At the target but arr not yet seen: hold so the target is not skipped.
                if (now_floor == des_floor && at_here) enter_door = arr;
                else if (has_above)                    des_n      = above;
                else                                   pick_new   = 1'b1;
            end
            S_DOWN: begin
                if (now_floor == des_floor && at_here) enter_door = arr;
                else if (has_below)                    des_n      = below;
                else                                   pick_new   = 1'b1;
            end
            default: begin
                clr = 1'b1;
                if (reload)          cnt_n = CNT_LOAD;
                else if (cnt != '0)  cnt_n = cnt - 1'b1;
                else begin
                    door_n   = 1'b0;
                    pick_new = 1'b1;
                end
            end
        endcase

        if (enter_door) begin
            state_n = S_DOOR;
            door_n  = 1'b1;
            cnt_n   = CNT_LOAD;
            clr     = 1'b1;
        end else if (pick_new) begin
            if (go_any && go_up) begin
                state_n = S_UP;
                dir_n   = DIR_UP;
                des_n   = above;
            end else if (go_any) begin
                state_n = S_DOWN;
                dir_n   = DIR_DOWN;
                des_n   = below;
            end else begin
                state_n = S_IDLE;
                dir_n   = DIR_IDLE;
                des_n   = now_floor;
            end
        end

        // Clear beats a same-cycle call for the floor being served.
        pend_n = (pending | call_req) & ~(clr ? here_mask : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            des_floor <= floor_t'(1);
            door_open <= 1'b0;
            dir       <= DIR_IDLE;
            pending   <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            // First edge after reset only arms; invalid floor readings freeze everything.
            if (armed && floor_ok) begin
                state     <= state_n;
                des_floor <= des_n;
                door_open <= door_n;
                dir       <= dir_n;
                pending   <= pend_n;
                cnt       <= cnt_n;
            end
        end
    end

endmodule

// File: tb/tb_floor_sched.sv
// Scoreboard bench for floor_sched: stimulus queues expected snapshots and door durations, a monitor checks them.
module tb_floor_sched;
    import elev_pkg::*;

    localparam int NF = 8;
    localparam int DT = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] call_req;
    floor_t        now_floor;
    logic          arr;
    logic          door_hold;
    floor_t        des_floor;
    logic          door_open;
    dir_t          dir;
    logic [NF-1:0] pending;

    floor_sched #(.N_FLOORS(NF), .DOOR_TIME(DT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call_req  (call_req),
        .now_floor (now_floor),
        .arr       (arr),
`ifdef FLOOR_SCHED_DOOR_HOLD_EN
        .door_hold (door_hold),
`endif
        .des_floor (des_floor),
        .door_open (door_open),
        .dir       (dir),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            at;
        string         name;
        floor_t        des;
        logic          door;
        logic [1:0]    dir;
        logic [NF-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   dur_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   open_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int at, input string name, input int des, input logic door,
                             input logic [1:0] d, input logic [NF-1:0] pend);
        exp_t e;
        e.at = at; e.name = name; e.des = floor_t'(des); e.door = door; e.dir = d; e.pend = pend;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares queued snapshots at their cycle and measures every door-open interval.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (e.at < cyc) begin
                n_fail++;
                $display("FAIL %s: check skipped at cycle %0d, required cycle %0d", e.name, cyc, e.at);
            end else if (des_floor !== e.des || door_open !== e.door || dir !== e.dir || pending !== e.pend) begin
                n_fail++;
                $display("FAIL %s: got des=%0d door=%0b dir=%b pend=%h, want des=%0d door=%0b dir=%b pend=%h",
                         e.name, des_floor, door_open, dir, pending, e.des, e.door, e.dir, e.pend);
            end
        end
        if (door_open === 1'b1) open_len++;
        else if (open_len > 0) begin
            n_tests++;
            if (dur_q.size() == 0) begin
                n_fail++;
                $display("FAIL door_len: got unexpected door interval %0d, want none", open_len);
            end else begin
                int want;
                want = dur_q.pop_front();
                if (open_len != want) begin
                    n_fail++;
                    $display("FAIL door_len: got %0d cycles open, want %0d", open_len, want);
                end
            end
            open_len = 0;
        end
    end

    initial begin
        int last;
        rst_n = 1'b0; call_req = '0; now_floor = 4'd1; arr = 1'b0; door_hold = 1'b0;
        expect_at(1, "reset", 1, 0, 2'b00, 8'h00);

        // Single call, serve floor 5, idle afterwards; first post-reset edge only arms.
        goto(2);   rst_n = 1'b1; call_req = 8'h10; expect_at(3, "arm_wait", 1, 0, 2'b00, 8'h00);
        goto(3);   expect_at(4, "call5", 1, 0, 2'b00, 8'h10);
        goto(4);   call_req = '0; expect_at(5, "go_up5", 5, 0, 2'b01, 8'h10);
        goto(5);   now_floor = 4'd5; arr = 1'b1; expect_at(6, "door5", 5, 1, 2'b01, 8'h00); dur_q.push_back(DT);
        goto(6);   arr = 1'b0;
        expect_at(25, "door5_last", 5, 1, 2'b01, 8'h00);
        expect_at(26, "close5", 5, 0, 2'b00, 8'h00);

        // Equal-distance tie from floor 4 goes up to 6, then reverses to 2.
        goto(27);  now_floor = 4'd4; call_req = 8'h22; expect_at(28, "tie_latch", 4, 0, 2'b00, 8'h22);
        goto(28);  call_req = '0; expect_at(29, "tie_up", 6, 0, 2'b01, 8'h22);
        goto(29);  now_floor = 4'd5; expect_at(30, "up6", 6, 0, 2'b01, 8'h22);
        goto(30);  now_floor = 4'd6; arr = 1'b1; expect_at(31, "door6", 6, 1, 2'b01, 8'h02); dur_q.push_back(DT);
        goto(31);  arr = 1'b0; expect_at(51, "rev_down2", 2, 0, 2'b10, 8'h02);
        goto(51);  now_floor = 4'd2; arr = 1'b1; expect_at(52, "door2", 2, 1, 2'b10, 8'h00); dur_q.push_back(DT);
        goto(52);  arr = 1'b0; expect_at(72, "idle2", 2, 0, 2'b00, 8'h00);

        // Heading to 7, invalid floor freezes, new call at 4 retargets, 7 resumes after.
        goto(72);  call_req = 8'h40; expect_at(73, "call7", 2, 0, 2'b00, 8'h40);
        goto(73);  call_req = '0; expect_at(74, "up7", 7, 0, 2'b01, 8'h40);
        goto(74);  now_floor = 4'd0; arr = 1'b1; expect_at(75, "bad_floor", 7, 0, 2'b01, 8'h40);
        goto(75);  now_floor = 4'd2; arr = 1'b0; call_req = 8'h08; expect_at(76, "call4", 7, 0, 2'b01, 8'h48);
        goto(76);  call_req = '0; expect_at(77, "retarget4", 4, 0, 2'b01, 8'h48);
        goto(77);  now_floor = 4'd3;
        goto(78);  now_floor = 4'd4; arr = 1'b1; expect_at(79, "door4", 4, 1, 2'b01, 8'h40); dur_q.push_back(DT);
        goto(79);  arr = 1'b0; expect_at(99, "resume7", 7, 0, 2'b01, 8'h40);

        // Call for the floor being passed stays pending; door reload at counter 10.
        goto(99);  now_floor = 4'd5; call_req = 8'h10; expect_at(100, "pass_call", 7, 0, 2'b01, 8'h50);
        goto(100); call_req = '0; now_floor = 4'd7; arr = 1'b1; expect_at(101, "door7", 7, 1, 2'b01, 8'h10);
        goto(101); arr = 1'b0;
        goto(110); call_req = 8'h40; expect_at(111, "reload", 7, 1, 2'b01, 8'h10);
        goto(111); call_req = '0; dur_q.push_back(DT + 10);
        expect_at(130, "reload_open", 7, 1, 2'b01, 8'h10);
        expect_at(131, "rev5", 5, 0, 2'b10, 8'h10);
        goto(131); now_floor = 4'd5; arr = 1'b1; expect_at(132, "door5b", 5, 1, 2'b10, 8'h00); dur_q.push_back(DT);
        goto(132); arr = 1'b0; expect_at(152, "idle5", 5, 0, 2'b00, 8'h00);

        // Idle with a call at the current floor opens the door directly.
        goto(152); call_req = 8'h10; expect_at(153, "call_here", 5, 0, 2'b00, 8'h10);
        goto(153); call_req = '0; expect_at(154, "idle_door", 5, 1, 2'b00, 8'h00); dur_q.push_back(DT);
        expect_at(174, "idle_close", 5, 0, 2'b00, 8'h00);

        // Asynchronous reset mid-travel with floors 6 and 8 pending.
        goto(174); now_floor = 4'd2; call_req = 8'hA0; expect_at(175, "latch_a0", 2, 0, 2'b00, 8'hA0);
        goto(175); call_req = '0; expect_at(176, "up_a0", 6, 0, 2'b01, 8'hA0);
        goto(177); now_floor = 4'd3;
        goto(178); #2; rst_n = 1'b0; expect_at(178, "async_rst", 1, 0, 2'b00, 8'h00);
        goto(180); rst_n = 1'b1;
        last = 190;
`ifdef FLOOR_SCHED_DOOR_HOLD_EN
        goto(181); call_req = 8'h04;
        goto(182); call_req = '0; expect_at(183, "hold_door", 3, 1, 2'b00, 8'h00);
        goto(185); door_hold = 1'b1; dur_q.push_back(322);
        goto(485); door_hold = 1'b0;
        expect_at(504, "hold_open", 3, 1, 2'b00, 8'h00);
        expect_at(505, "hold_close", 3, 0, 2'b00, 8'h00);
        last = 515;
`endif
        goto(last);
        n_tests++;
        if (exp_q.size() != 0 || dur_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d snapshots and %0d door intervals unchecked, want 0 and 0",
                     exp_q.size(), dur_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
